// File: rtl/bin_clause_sequencer.sv
// bin_clause_sequencer: moves one bin of clauses between the clause BRAM and the core clause array.
// Ports:
//   clk, rst (async, active-low)
//   start_load_i / start_update_i / bin_id_i : transfer request, bin sampled with the start
//   busy_o, done_o                           : transfer in progress / one-cycle completion pulse
//   ram_we_c_o, ram_addr_c_o, ram_din_c_o    : clause BRAM write enable, address, write data
//   ram_dout_c_i                             : clause BRAM read data (1-cycle latency)
//   wr_carray_o, rd_carray_o                 : one-hot core row write strobe / read select
//   clause_o, clause_i                       : clause to / from the core
module bin_clause_sequencer #(
    parameter int NUM_CLAUSES_A_BIN  = 8,
    parameter int NUM_VARS_A_BIN     = 8,
    parameter int WIDTH_BIN_ID       = 10,
    parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
    parameter int ADDR_WIDTH_CLAUSES = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_load_i,
    input  logic                          start_update_i,
    input  logic [WIDTH_BIN_ID-1:0]       bin_id_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          ram_we_c_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_o,
    output logic [WIDTH_CLAUSES-1:0]      ram_din_c_o,
    input  logic [WIDTH_CLAUSES-1:0]      ram_dout_c_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o,
    output logic [WIDTH_CLAUSES-1:0]      clause_o,
    input  logic [WIDTH_CLAUSES-1:0]      clause_i
);
    localparam int N  = NUM_CLAUSES_A_BIN;
    localparam int AW = ADDR_WIDTH_CLAUSES;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_base, w_base;
    logic            r_busy, r_done, r_we, w_busy, w_done, w_we;
    logic [AW-1:0]   r_addr, w_addr;
    logic [N-1:0]    r_wr, r_rd, w_wr, w_rd;

    // Address 0 is reserved, so bin rows start one above bin_id*N.
    assign w_base = AW'(32'(bin_id_i) * 32'(N) + 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start_load_i ? S_LOAD : (start_update_i ? S_UPDATE : S_IDLE);
            S_LOAD:   w_next = (r_cnt == CW'(N)) ? S_DONE : S_LOAD;
            S_UPDATE: w_next = (r_cnt == CW'(N - 1)) ? S_DONE : S_UPDATE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so the state
    // leads the visible outputs by one cycle. In LOAD, count c reads row c
    // and writes row c-1 (the BRAM data of the previous read).
    always_comb begin
        w_busy = r_state != S_IDLE;
        w_done = r_state == S_DONE;
        w_we   = r_state == S_UPDATE;
        w_addr = ((r_state == S_LOAD && r_cnt < CW'(N)) || w_we) ? r_base + AW'(r_cnt) : '0;
        w_wr   = (r_state == S_LOAD && r_cnt != '0) ? ONE << (r_cnt - 1'b1) : '0;
        w_rd   = w_we ? ONE << r_cnt : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
        end else begin
            r_cnt  <= (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
            r_base <= (r_state == S_IDLE) ? w_base : r_base;
            r_busy <= w_busy;
            r_done <= w_done;
            r_we   <= w_we;
            r_addr <= w_addr;
            r_wr   <= w_wr;
            r_rd   <= w_rd;
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign ram_we_c_o   = r_we;
    assign ram_addr_c_o = r_addr;
    assign wr_carray_o  = r_wr;
    assign rd_carray_o  = r_rd;
    assign ram_din_c_o  = clause_i;
    // BRAM read data arrives in the same cycle as its row strobe, so it is
    // forwarded directly; gating keeps clause_o at 0 outside write cycles.
    assign clause_o     = (r_wr != '0) ? ram_dout_c_i : '0;
endmodule

// File: tb/tb_bin_clause_sequencer.sv
module tb_bin_clause_sequencer;
    localparam int N  = 8;
    localparam int AW = 9;
    localparam int W  = 16;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_load_i = 1'b0;
    logic start_update_i = 1'b0;
    logic [9:0] bin_id_i = '0;
    logic busy_o, done_o, ram_we_c_o;
    logic [AW-1:0] ram_addr_c_o;
    logic [W-1:0] ram_din_c_o, ram_dout_c_i, clause_o, clause_i;
    logic [N-1:0] wr_carray_o, rd_carray_o;

    logic [W-1:0] bram [DEPTH];
    logic [W-1:0] core [N];
    int ref_mem [DEPTH];
    int ref_core [N];
    int n_tests = 0;
    int n_fail = 0;
    int zero_wr = 0;
    int viol = 0;

    typedef struct {
        int op;
        int bin;
        int base;
        int done_cyc;
        int poke;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    bin_clause_sequencer dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_update_i(start_update_i), .bin_id_i(bin_id_i),
        .busy_o(busy_o), .done_o(done_o),
        .ram_we_c_o(ram_we_c_o), .ram_addr_c_o(ram_addr_c_o), .ram_din_c_o(ram_din_c_o),
        .ram_dout_c_i(ram_dout_c_i),
        .wr_carray_o(wr_carray_o), .rd_carray_o(rd_carray_o),
        .clause_o(clause_o), .clause_i(clause_i)
    );

    always @(posedge clk) begin
        if (ram_we_c_o) bram[ram_addr_c_o] <= ram_din_c_o;
        if (ram_we_c_o && ram_addr_c_o == '0) zero_wr <= zero_wr + 1;
        ram_dout_c_i <= bram[ram_addr_c_o];
        for (int k = 0; k < N; k++) if (wr_carray_o[k]) core[k] <= clause_o;
    end

    always_comb begin
        clause_i = '0;
        for (int k = 0; k < N; k++) if (rd_carray_o[k]) clause_i = core[k];
    end

    always @(negedge clk)
        if (rst && ((wr_carray_o != '0 && rd_carray_o != '0) || !$onehot0(wr_carray_o) || !$onehot0(rd_carray_o)))
            viol <= viol + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " busy"}, busy_o, 0);
        chk({nm, " done"}, done_o, 0);
        chk({nm, " we"}, ram_we_c_o, 0);
        chk({nm, " addr"}, ram_addr_c_o, 0);
        chk({nm, " wr"}, wr_carray_o, 0);
        chk({nm, " rd"}, rd_carray_o, 0);
        chk({nm, " clause"}, clause_o, 0);
    endtask

    // op: 0 load, 1 update, 2 both starts (load wins). poke = cycle in which a
    // stray update start is raised for one cycle (-1 for none).
    task automatic run_xfer(input int op, input int bin, input int eb, input int ed, input int poke);
        int exp_wr;
        bit act;
        @(negedge clk);
        start_load_i = (op != 1);
        start_update_i = (op != 0);
        bin_id_i = 10'(bin);
        @(posedge clk);
        #1;
        start_load_i = 1'b0;
        start_update_i = 1'b0;
        bin_id_i = 10'($urandom);
        for (int c = 0; c <= ed + 1; c++) begin
            @(negedge clk);
            start_update_i = (c == poke);
            chk($sformatf("bin%0d c%0d busy", bin, c), busy_o, c >= 1 && c <= ed);
            chk($sformatf("bin%0d c%0d done", bin, c), done_o, c == ed);
            if (op != 1) begin
                chk($sformatf("bin%0d c%0d we", bin, c), ram_we_c_o, 0);
                chk($sformatf("bin%0d c%0d rd", bin, c), rd_carray_o, 0);
                if (c >= 1 && c <= N)
                    chk($sformatf("bin%0d c%0d raddr", bin, c), ram_addr_c_o, (eb + c - 1) % DEPTH);
                exp_wr = (c >= 2 && c <= N + 1) ? (1 << (c - 2)) : 0;
                chk($sformatf("bin%0d c%0d wr", bin, c), wr_carray_o, exp_wr);
                if (exp_wr != 0)
                    chk($sformatf("bin%0d c%0d clause", bin, c), clause_o, ref_mem[(eb + c - 2) % DEPTH]);
            end else begin
                act = c >= 1 && c <= N;
                chk($sformatf("bin%0d c%0d we", bin, c), ram_we_c_o, act);
                chk($sformatf("bin%0d c%0d rd", bin, c), rd_carray_o, act ? (1 << (c - 1)) : 0);
                chk($sformatf("bin%0d c%0d wr", bin, c), wr_carray_o, 0);
                if (act) begin
                    chk($sformatf("bin%0d c%0d waddr", bin, c), ram_addr_c_o, (eb + c - 1) % DEPTH);
                    chk($sformatf("bin%0d c%0d din", bin, c), ram_din_c_o, ref_core[c - 1]);
                end
            end
        end
        start_update_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (op != 1) begin
                ref_core[k] = ref_mem[(eb + k) % DEPTH];
                chk($sformatf("bin%0d core[%0d]", bin, k), core[k], ref_core[k]);
            end else begin
                ref_mem[(eb + k) % DEPTH] = ref_core[k];
                chk($sformatf("bin%0d bram[%0d]", bin, (eb + k) % DEPTH), bram[(eb + k) % DEPTH], ref_mem[(eb + k) % DEPTH]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        int v, op, bin, first, second;
        vecs[0] = '{op: 1, bin: 2,  base: 17, done_cyc: 9,  poke: -1};
        vecs[1] = '{op: 0, bin: 0,  base: 1,  done_cyc: 10, poke: -1};
        vecs[2] = '{op: 2, bin: 1,  base: 9,  done_cyc: 10, poke: 4};
        vecs[3] = '{op: 0, bin: 70, base: 49, done_cyc: 10, poke: -1};
        vecs[4] = '{op: 1, bin: 5,  base: 41, done_cyc: 9,  poke: -1};
        vecs[5] = '{op: 0, bin: 64, base: 1,  done_cyc: 10, poke: -1};
        for (int a = 0; a < DEPTH; a++) begin
            v = (a >= 1 && a <= N) ? a : int'($urandom_range(0, 16'hffff));
            bram[a] <= W'(v);
            ref_mem[a] = v;
        end
        for (int k = 0; k < N; k++) begin
            core[k] <= W'(16'hA000 | k);
            ref_core[k] = 16'hA000 | k;
        end

        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post-reset");

        for (int i = 0; i < 6; i++)
            run_xfer(vecs[i].op, vecs[i].bin, vecs[i].base, vecs[i].done_cyc, vecs[i].poke);

        for (int i = 0; i < 25; i++) begin
            op = $urandom_range(0, 2);
            do bin = $urandom_range(0, 1023); while (bin % 64 == 63);
            run_xfer(op, bin, (bin * N + 1) % DEPTH, (op == 1) ? N + 1 : N + 2, -1);
        end

        @(negedge clk);
        start_update_i = 1'b1;
        bin_id_i = 10'd3;
        @(posedge clk);
        #1;
        start_update_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("mid-update reset");
        for (int k = 0; k < 3; k++) ref_mem[25 + k] = ref_core[k];
        repeat (2) @(negedge clk);
        chk_idle("held reset");
        rst = 1'b1;
        for (int k = 0; k < N; k++) chk($sformatf("partial bram[%0d]", 25 + k), bram[25 + k], ref_mem[25 + k]);
        run_xfer(0, 0, 1, N + 2, -1);

        @(negedge clk);
        start_load_i = 1'b1;
        bin_id_i = 10'd0;
        first = -1;
        second = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        start_load_i = 1'b0;
        for (int c = 0; c < 30 && busy_o; c++) @(negedge clk);
        chk("b2b idle", busy_o, 0);
        chk("b2b first done", first, N + 2);
        chk("b2b done spacing", second - first, N + 3);
        for (int k = 0; k < N; k++) begin
            ref_core[k] = ref_mem[1 + k];
            chk($sformatf("b2b core[%0d]", k), core[k], ref_core[k]);
        end

        chk("writes to address 0", zero_wr, 0);
        chk("row strobe violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
